// File: rtl/arb_pkg.sv
// Shared definitions for the eight-way round-robin arbiter: channel sizing,
// FSM state type and the rotating-priority search.
package arb_pkg;

  localparam int CHANNELS  = 8;
  localparam int SEL_WIDTH = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Returns {found, index}: the first set bit of req searched from ptr
  // upwards, wrapping modulo CHANNELS. Iterating from the far end lets the
  // nearest candidate overwrite the result last.
  function automatic logic [SEL_WIDTH:0] rr_pick(
    input logic [CHANNELS-1:0]  req,
    input logic [SEL_WIDTH-1:0] ptr
  );
    logic [SEL_WIDTH:0]   res;
    logic [SEL_WIDTH-1:0] idx;
    res = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      idx = ptr + SEL_WIDTH'(k);
      if (req[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/multiplexer8.sv
// Eight-way WIDTH-bit data multiplexer; sel picks which input drives out.
module multiplexer8 #(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  input  logic [WIDTH-1:0] in5,
  input  logic [WIDTH-1:0] in6,
  input  logic [WIDTH-1:0] in7,
  output logic [WIDTH-1:0] out
);

  always_comb begin
    out = in0;
    unique case (sel)
      3'd0: out = in0;
      3'd1: out = in1;
      3'd2: out = in2;
      3'd3: out = in3;
      3'd4: out = in4;
      3'd5: out = in5;
      3'd6: out = in6;
      3'd7: out = in7;
      default: out = in0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter sharing one valid/ready downstream port between eight
// requesters, with bursts capped at MAX_HOLD beats per grant.
//
// state | meaning
// IDLE  | no grant held; search req_valid from ptr for the next winner
// GRANT | requester gnt owns the downstream port until its burst ends
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [CHANNELS-1:0]          req_valid,
  input  logic [CHANNELS-1:0]          req_last,
  input  logic [CHANNELS*WIDTH-1:0]    req_data,
  output logic [CHANNELS-1:0]          req_ready,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  output logic [SEL_WIDTH-1:0]         out_sel,
  output logic                         out_last,
  input  logic                         out_ready,
  output logic                         busy
);

  if (MAX_HOLD < 1 || MAX_HOLD > 16) begin : g_bad_hold
    $error("rr_arbiter8: MAX_HOLD must lie in 1..16");
  end

  localparam logic [3:0] LAST_CNT = 4'(MAX_HOLD - 1);

  arb_state_t           state_q, state_d;
  logic [SEL_WIDTH-1:0] gnt_q, gnt_d;
  logic [SEL_WIDTH-1:0] ptr_q, ptr_d;
  logic [3:0]           cnt_q, cnt_d;

  logic [SEL_WIDTH:0]   pick;
  logic                 xfer;
  logic                 end_grant;
  logic [WIDTH-1:0]     mux_out;

  assign pick = rr_pick(req_valid, ptr_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // A withdrawn request (valid low) can never coincide with a transfer, so
  // the withdrawal term needs no explicit "and no transfer" qualifier.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    xfer      = 1'b0;
    end_grant = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick[SEL_WIDTH]) begin
          gnt_d   = pick[SEL_WIDTH-1:0];
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        xfer      = req_valid[gnt_q] & out_ready;
        end_grant = (xfer & (req_last[gnt_q] | (cnt_q == LAST_CNT)))
                  | ~req_valid[gnt_q];
        if (end_grant) begin
          ptr_d   = gnt_q + 1'b1;
          state_d = IDLE;
        end else if (xfer) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset suppresses the handshake outright so an in-flight beat is never
  // seen as accepted by either side.
  always_comb begin
    req_ready = '0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    if (state_q == GRANT) begin
      out_last = req_last[gnt_q];
      if (!reset) begin
        out_valid        = req_valid[gnt_q];
        req_ready[gnt_q] = out_ready;
      end
    end
  end

  assign out_sel  = gnt_q;
  assign busy     = (state_q == GRANT);
  assign out_data = mux_out;

  multiplexer8 #(
    .WIDTH (WIDTH)
  ) u_mux (
    .sel (gnt_q),
    .in0 (req_data[0*WIDTH +: WIDTH]),
    .in1 (req_data[1*WIDTH +: WIDTH]),
    .in2 (req_data[2*WIDTH +: WIDTH]),
    .in3 (req_data[3*WIDTH +: WIDTH]),
    .in4 (req_data[4*WIDTH +: WIDTH]),
    .in5 (req_data[5*WIDTH +: WIDTH]),
    .in6 (req_data[6*WIDTH +: WIDTH]),
    .in7 (req_data[7*WIDTH +: WIDTH]),
    .out (mux_out)
  );

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed scenarios plus randomized
// traffic compared against a behavioural round-robin model.
module tb_rr_arbiter8;
  import arb_pkg::*;

  localparam int W  = 32;
  localparam int MH = 4;

  logic            clock = 1'b0;
  logic            reset;
  logic [7:0]      req_valid, req_last, req_ready;
  logic [8*W-1:0]  req_data;
  logic            out_valid, out_last, out_ready, busy;
  logic [W-1:0]    out_data;
  logic [2:0]      out_sel;

  always #5 clock = ~clock;

  rr_arbiter8 #(.WIDTH(W), .MAX_HOLD(MH)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one owner at a time, rotating priority pointer.
  bit m_busy = 1'b0;
  int m_gnt = 0, m_ptr = 0, m_cnt = 0;

  task automatic model_step();
    bit x;
    if (reset) begin
      m_busy = 0; m_gnt = 0; m_ptr = 0; m_cnt = 0;
    end else if (!m_busy) begin
      for (int k = 0; k < 8; k++) begin
        if (req_valid[(m_ptr + k) % 8]) begin
          m_gnt = (m_ptr + k) % 8; m_cnt = 0; m_busy = 1;
          break;
        end
      end
    end else begin
      x = req_valid[m_gnt] && out_ready;
      if ((x && (req_last[m_gnt] || m_cnt == MH - 1)) || !req_valid[m_gnt]) begin
        m_ptr = (m_gnt + 1) % 8; m_busy = 0;
      end else if (x) begin
        m_cnt++;
      end
    end
  endtask

  // Requester agents: rem = beats left; mode 0 last on final beat,
  // 1 never last, 2 last on every beat.
  int         rem [8];
  int         mode[8];
  logic [W-1:0] dat[8];
  logic [7:0] last_acc = '0;

  task automatic drive();
    for (int i = 0; i < 8; i++) begin
      req_valid[i] = rem[i] > 0;
      req_last[i]  = (rem[i] > 0) && (mode[i] == 2 || (mode[i] == 0 && rem[i] == 1));
      req_data[i*W +: W] = dat[i];
    end
  endtask

  task automatic agent_update();
    for (int i = 0; i < 8; i++) begin
      if (last_acc[i]) begin
        rem[i]--;
        dat[i] = $urandom;
      end
    end
    drive();
  endtask

  int   grant_log[$], grant_cyc[$], xfer_log[$], xfer_cyc[$];
  bit   prev_busy = 1'b0;
  logic [7:0] ready_seen = '0;
  int   cyc_n = 0;

  function automatic int q_at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic clear_logs();
    grant_log.delete(); grant_cyc.delete(); xfer_log.delete(); xfer_cyc.delete();
    ready_seen = '0;
  endtask

  task automatic cyc();
    logic [7:0]   er;
    logic         ev, el;
    logic [W-1:0] ed;
    @(negedge clock);
    ev = m_busy && req_valid[m_gnt] && !reset;
    er = (m_busy && out_ready && !reset) ? 8'(1 << m_gnt) : 8'h00;
    el = m_busy && req_last[m_gnt];
    ed = req_data[m_gnt*W +: W];
    chk("out_valid", 64'(out_valid), 64'(ev));
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("out_sel",   64'(out_sel),   64'(m_gnt));
    chk("out_last",  64'(out_last),  64'(el));
    chk("busy",      64'(busy),      64'(m_busy));
    chk("out_data",  64'(out_data),  64'(ed));
    ready_seen |= req_ready;
    if (busy && !prev_busy) begin
      grant_log.push_back(int'(out_sel)); grant_cyc.push_back(cyc_n);
    end
    if (out_valid && out_ready) begin
      xfer_log.push_back(int'(out_sel)); xfer_cyc.push_back(cyc_n);
    end
    prev_busy = busy;
    last_acc  = er & req_valid;
    cyc_n++;
    @(posedge clock);
    model_step();
    #1;
    agent_update();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_sel"},   64'(out_sel),   64'd0);
    chk({tag, "_last"},  64'(out_last),  64'd0);
    chk({tag, "_busy"},  64'(busy),      64'd0);
    chk({tag, "_data"},  64'(out_data),  64'(req_data[0 +: W]));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin rem[i] = 0; mode[i] = 0; end
    drive();
    cyc();
    cyc();
    reset = 1'b0;
    clear_logs();
  endtask

  initial begin
    reset = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin rem[i] = 0; mode[i] = 0; dat[i] = $urandom; end
    drive();
    repeat (2) @(posedge clock);
    #1;
    check_reset_outputs("rst0");
    reset = 1'b0;

    // Single requester, 3-beat burst
    do_reset();
    rem[2] = 3; drive(); out_ready = 1'b1;
    repeat (6) cyc();
    chk("t1_ngrant", 64'(grant_log.size()), 64'd1);
    chk("t1_gnt",    64'(q_at(grant_log, 0)), 64'd2);
    chk("t1_nxfer",  64'(xfer_log.size()), 64'd3);
    chk("t1_b2b",    64'(q_at(xfer_cyc, 2) - q_at(xfer_cyc, 0)), 64'd2);
    chk("t1_busy",   64'(busy), 64'd0);

    // Fairness 0/7 with wrap-around
    do_reset();
    rem[0] = 100; mode[0] = 2; rem[7] = 100; mode[7] = 2; drive(); out_ready = 1'b1;
    repeat (9) cyc();
    chk("t2_ngrant", 64'(grant_log.size()), 64'd4);
    chk("t2_g0", 64'(q_at(grant_log, 0)), 64'd0);
    chk("t2_g1", 64'(q_at(grant_log, 1)), 64'd7);
    chk("t2_g2", 64'(q_at(grant_log, 2)), 64'd0);
    chk("t2_g3", 64'(q_at(grant_log, 3)), 64'd7);
    chk("t2_gap", 64'(q_at(grant_cyc, 1) - q_at(grant_cyc, 0)), 64'd2);

    // MAX_HOLD cut
    do_reset();
    rem[5] = 6; mode[5] = 1; rem[6] = 2; mode[6] = 0; drive(); out_ready = 1'b1;
    repeat (14) cyc();
    chk("t3_ngrant", 64'(grant_log.size()), 64'd3);
    chk("t3_g0", 64'(q_at(grant_log, 0)), 64'd5);
    chk("t3_g1", 64'(q_at(grant_log, 1)), 64'd6);
    chk("t3_g2", 64'(q_at(grant_log, 2)), 64'd5);
    chk("t3_nxfer", 64'(xfer_log.size()), 64'd8);
    chk("t3_x3", 64'(q_at(xfer_log, 3)), 64'd5);
    chk("t3_x4", 64'(q_at(xfer_log, 4)), 64'd6);
    chk("t3_x6", 64'(q_at(xfer_log, 6)), 64'd5);

    // Backpressure during a 2-beat burst
    do_reset();
    rem[3] = 2; drive();
    begin
      logic [5:0] ors;
      ors = 6'b110011;
      for (int c = 5; c >= 0; c--) begin
        out_ready = ors[c];
        cyc();
      end
    end
    chk("t4_nxfer", 64'(xfer_log.size()), 64'd2);
    chk("t4_gap", 64'(q_at(xfer_cyc, 1) - q_at(xfer_cyc, 0)), 64'd3);

    // Withdrawal before any transfer
    do_reset();
    rem[1] = 3; drive(); out_ready = 1'b0;
    cyc();
    rem[1] = 0; drive();
    cyc();
    chk("t5_noready", 64'(ready_seen), 64'd0);
    chk("t5_idle", 64'(busy), 64'd0);
    rem[0] = 1; rem[3] = 1; drive(); out_ready = 1'b1;
    repeat (5) cyc();
    chk("t5_ngrant", 64'(grant_log.size()), 64'd3);
    chk("t5_g1", 64'(q_at(grant_log, 1)), 64'd3);
    chk("t5_g2", 64'(q_at(grant_log, 2)), 64'd0);

    // Mid-burst reset
    do_reset();
    rem[4] = 4; drive(); out_ready = 1'b1;
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    check_reset_outputs("t6");
    reset = 1'b0;
    clear_logs();
    rem[2] = 1; drive();
    repeat (8) cyc();
    chk("t6_ngrant", 64'(grant_log.size()), 64'd2);
    chk("t6_g0", 64'(q_at(grant_log, 0)), 64'd2);
    chk("t6_g1", 64'(q_at(grant_log, 1)), 64'd4);
    chk("t6_nxfer", 64'(xfer_log.size()), 64'd4);

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 8; i++) begin
        if (rem[i] == 0 && $urandom_range(0, 3) == 0) begin
          rem[i]  = $urandom_range(1, 6);
          mode[i] = $urandom_range(0, 2);
          dat[i]  = $urandom;
        end else if (rem[i] > 0 && $urandom_range(0, 49) == 0) begin
          rem[i] = 0;
        end
      end
      reset     = ($urandom_range(0, 199) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      drive();
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
